// File: rtl/agex_stage_pkg.sv
// Shared AGEX definitions: datapath widths, internal opcode enum and the AGEX latch layout that MEM unpacks.
package agex_stage_pkg;

    localparam int DBITS     = 32;
    localparam int IOPBITS   = 6;
    localparam int REGNOBITS = 5;

    typedef enum logic [IOPBITS-1:0] {
        ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLT_I, SLTU_I, SLL_I, SRL_I, SRA_I,
        ADDI_I, ANDI_I, ORI_I, XORI_I, SLTI_I, SLTIU_I, SLLI_I, SRLI_I, SRAI_I,
        LUI_I, AUIPC_I, LW_I, SW_I,
        BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I, JAL_I, JALR_I,
        MUL_I, CSRR_I, CSRW_I,
        INVALID_I = 6'h3F
    } iop_e;

    // Field order is the MEM-side unpack order, MSB first.
    typedef struct packed {
        logic                 valid;
        logic [IOPBITS-1:0]   op;
        logic [DBITS-1:0]     pc;
        logic [DBITS-1:0]     result;
        logic [DBITS-1:0]     store_data;
        logic [REGNOBITS-1:0] rd;
        logic                 wr_reg;
        logic [DBITS-1:0]     inst_count;
    } agex_latch_t;

    localparam int AGEX_LATCH_BITS = $bits(agex_latch_t);

endpackage

// File: rtl/agex_stage_if.sv
// Decode-latch inputs, fetch/decode control and AGEX-latch outputs of the execute stage.
interface agex_stage_if;
    import agex_stage_pkg::*;

    logic                 in_valid;
    logic [IOPBITS-1:0]   in_op;
    logic [DBITS-1:0]     in_pc;
    logic [DBITS-1:0]     in_rs1;
    logic [DBITS-1:0]     in_rs2;
    logic [DBITS-1:0]     in_imm;
    logic [REGNOBITS-1:0] in_rd;
    logic                 in_wr_reg;
    logic [DBITS-1:0]     in_inst_count;

    logic                 stall_o;
    logic                 redirect_o;
    logic [DBITS-1:0]     redirect_pc_o;

    logic                 out_valid;
    logic [IOPBITS-1:0]   out_op;
    logic [DBITS-1:0]     out_pc;
    logic [DBITS-1:0]     out_result;
    logic [DBITS-1:0]     out_store_data;
    logic [REGNOBITS-1:0] out_rd;
    logic                 out_wr_reg;
    logic [DBITS-1:0]     out_inst_count;

    modport master (
        output in_valid, in_op, in_pc, in_rs1, in_rs2, in_imm, in_rd, in_wr_reg, in_inst_count,
        input  stall_o, redirect_o, redirect_pc_o,
        input  out_valid, out_op, out_pc, out_result, out_store_data, out_rd, out_wr_reg, out_inst_count
    );

    modport slave (
        input  in_valid, in_op, in_pc, in_rs1, in_rs2, in_imm, in_rd, in_wr_reg, in_inst_count,
        output stall_o, redirect_o, redirect_pc_o,
        output out_valid, out_op, out_pc, out_result, out_store_data, out_rd, out_wr_reg, out_inst_count
    );

endinterface

// File: rtl/agex_iter_mul.sv
// Iterative shift-add multiplier retiring RADIX_BITS multiplier bits per busy cycle; low DBITS of the product.
module agex_iter_mul #(
    parameter int DBITS      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DBITS-1:0] mcand,
    input  logic [DBITS-1:0] mplier,
    output logic             busy,
    output logic             last,
    output logic [DBITS-1:0] product
);

    localparam int CYCLES   = DBITS / RADIX_BITS;
    localparam int CNT_BITS = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e              state_reg, state_next;
    logic [CNT_BITS-1:0] count_reg, count_next;
    logic [DBITS-1:0]    mcand_reg, mcand_next;
    logic [DBITS-1:0]    mplier_reg, mplier_next;
    logic [DBITS-1:0]    acc_reg, acc_next;
    logic [DBITS-1:0]    partial [RADIX_BITS];
    logic [DBITS-1:0]    partial_sum;

    generate
        for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_partial
            assign partial[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        partial_sum = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            partial_sum = partial_sum + partial[i];
        end
    end

    // Product includes the digit retired in the current cycle, so it is final while last is high.
    assign product = acc_reg + partial_sum;
    assign busy    = (state_reg == BUSY);
    assign last    = busy && (count_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = BUSY;
                    count_next  = CNT_BITS'(CYCLES - 1);
                    mcand_next  = mcand;
                    mplier_next = mplier;
                    acc_next    = '0;
                end
            end
            BUSY: begin
                acc_next    = product;
                mcand_next  = mcand_reg << RADIX_BITS;
                mplier_next = mplier_reg >> RADIX_BITS;
                count_next  = count_reg - CNT_BITS'(1);
                if (count_reg == '0) begin
                    state_next = IDLE;
                    count_next = '0;
                    acc_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/agex_stage.sv
// RV32 execute / address-generation stage: ALU, branch resolution, fetch redirect and MUL.
// AGEX_FAST_MUL_EN selects a single-cycle multiply instead of the iterative multiplier.
module agex_stage
    import agex_stage_pkg::*;
#(
    parameter int MUL_RADIX_BITS = 1
) (
    input  logic         clk,
    input  logic         reset,
    agex_stage_if.slave  bus
);

    logic [DBITS-1:0] alu_result;
    logic             known_op;
    logic             taken;
    logic [DBITS-1:0] target;
    logic             is_mul;
    agex_latch_t      latch_reg, latch_next;

    always_comb begin
        alu_result = '0;
        known_op   = 1'b1;
        taken      = 1'b0;
        is_mul     = 1'b0;
        target     = bus.in_pc + bus.in_imm;
        case (bus.in_op)
            ADD_I:   alu_result = bus.in_rs1 + bus.in_rs2;
            SUB_I:   alu_result = bus.in_rs1 - bus.in_rs2;
            AND_I:   alu_result = bus.in_rs1 & bus.in_rs2;
            OR_I:    alu_result = bus.in_rs1 | bus.in_rs2;
            XOR_I:   alu_result = bus.in_rs1 ^ bus.in_rs2;
            SLT_I:   alu_result = DBITS'($signed(bus.in_rs1) < $signed(bus.in_rs2));
            SLTU_I:  alu_result = DBITS'(bus.in_rs1 < bus.in_rs2);
            SLL_I:   alu_result = bus.in_rs1 << bus.in_rs2[4:0];
            SRL_I:   alu_result = bus.in_rs1 >> bus.in_rs2[4:0];
            SRA_I:   alu_result = $signed(bus.in_rs1) >>> bus.in_rs2[4:0];
            ADDI_I:  alu_result = bus.in_rs1 + bus.in_imm;
            ANDI_I:  alu_result = bus.in_rs1 & bus.in_imm;
            ORI_I:   alu_result = bus.in_rs1 | bus.in_imm;
            XORI_I:  alu_result = bus.in_rs1 ^ bus.in_imm;
            SLTI_I:  alu_result = DBITS'($signed(bus.in_rs1) < $signed(bus.in_imm));
            SLTIU_I: alu_result = DBITS'(bus.in_rs1 < bus.in_imm);
            SLLI_I:  alu_result = bus.in_rs1 << bus.in_imm[4:0];
            SRLI_I:  alu_result = bus.in_rs1 >> bus.in_imm[4:0];
            SRAI_I:  alu_result = $signed(bus.in_rs1) >>> bus.in_imm[4:0];
            LUI_I:   alu_result = bus.in_imm;
            AUIPC_I: alu_result = bus.in_pc + bus.in_imm;
            LW_I, SW_I:     alu_result = bus.in_rs1 + bus.in_imm;
            CSRR_I, CSRW_I: alu_result = bus.in_rs1;
            BEQ_I:   taken = (bus.in_rs1 == bus.in_rs2);
            BNE_I:   taken = (bus.in_rs1 != bus.in_rs2);
            BLT_I:   taken = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
            BGE_I:   taken = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
            BLTU_I:  taken = (bus.in_rs1 <  bus.in_rs2);
            BGEU_I:  taken = (bus.in_rs1 >= bus.in_rs2);
            JAL_I: begin
                taken      = 1'b1;
                alu_result = bus.in_pc + DBITS'(4);
            end
            JALR_I: begin
                taken      = 1'b1;
                target     = (bus.in_rs1 + bus.in_imm) & ~DBITS'(1);
                alu_result = bus.in_pc + DBITS'(4);
            end
            MUL_I: begin
                is_mul = 1'b1;
`ifdef AGEX_FAST_MUL_EN
                alu_result = bus.in_rs1 * bus.in_rs2;
`endif
            end
            default: known_op = 1'b0;
        endcase
    end

    assign bus.redirect_o    = bus.in_valid && taken;
    assign bus.redirect_pc_o = target;

`ifdef AGEX_FAST_MUL_EN
    assign bus.stall_o = 1'b0;
`else
    logic             mul_start;
    logic             mul_busy;
    logic             mul_last;
    logic [DBITS-1:0] mul_product;

    // No start while busy: the held MUL must not be re-accepted on its completion cycle.
    assign mul_start   = bus.in_valid && is_mul && !mul_busy;
    assign bus.stall_o = !reset && (mul_start || (mul_busy && !mul_last));

    agex_iter_mul #(
        .DBITS      (DBITS),
        .RADIX_BITS (MUL_RADIX_BITS)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .mcand   (bus.in_rs1),
        .mplier  (bus.in_rs2),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (mul_product)
    );
`endif

    always_comb begin
        latch_next = '0;
        if (bus.in_valid) begin
            latch_next.valid      = 1'b1;
            latch_next.op         = bus.in_op;
            latch_next.pc         = bus.in_pc;
            latch_next.result     = alu_result;
            latch_next.store_data = bus.in_rs2;
            latch_next.rd         = bus.in_rd;
            latch_next.wr_reg     = bus.in_wr_reg && known_op;
            latch_next.inst_count = bus.in_inst_count;
        end
`ifndef AGEX_FAST_MUL_EN
        if (mul_last) begin
            latch_next.result = mul_product;
        end else if (mul_start || mul_busy) begin
            latch_next = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_reg <= '0;
        end else begin
            latch_reg <= latch_next;
        end
    end

    assign bus.out_valid      = latch_reg.valid;
    assign bus.out_op         = latch_reg.op;
    assign bus.out_pc         = latch_reg.pc;
    assign bus.out_result     = latch_reg.result;
    assign bus.out_store_data = latch_reg.store_data;
    assign bus.out_rd         = latch_reg.rd;
    assign bus.out_wr_reg     = latch_reg.wr_reg;
    assign bus.out_inst_count = latch_reg.inst_count;

endmodule

// File: doc/agex_stage.md
Name: agex_stage

Overview:
- Execute / address-generation stage of the 5-stage in-order RV32 pipeline (FE, DE, AGEX, MEM, WB).
- Consumes the decoded instruction and operands from the decode latch.
- Computes ALU results, load/store addresses and branch/jump outcomes, and redirects fetch on taken control flow.
- Runs MUL on an iterative multiplier that stalls decode; writes the AGEX pipeline latch feeding MEM.

Parameters:
- DBITS, 32, datapath width.
- IOPBITS, 6, width of the internal opcode enum.
- REGNOBITS, 5, register index width.
- MUL_RADIX_BITS, 1, multiplier bits retired per busy cycle (1, 2, 4 or 8); MUL_CYCLES = DBITS/MUL_RADIX_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode latch holds a real instruction (0 = bubble)
- in_op  in  IOPBITS  internal opcode enum
- in_pc  in  DBITS  instruction PC
- in_rs1  in  DBITS  rs1 value
- in_rs2  in  DBITS  rs2 value
- in_imm  in  DBITS  sign-extended immediate
- in_rd  in  REGNOBITS  destination register
- in_wr_reg  in  1  instruction writes rd
- in_inst_count  in  DBITS  retire-trace tag, passed through
- stall_o  out  1  to DE: hold the decode latch
- redirect_o  out  1  to FE/DE: squash wrong-path instructions and refetch
- redirect_pc_o  out  DBITS  refetch target
- out_valid  out  1  AGEX latch valid
- out_op  out  IOPBITS  opcode passthrough
- out_pc  out  DBITS  PC passthrough
- out_result  out  DBITS  ALU result / memory address / link value
- out_store_data  out  DBITS  rs2 value, meaningful for SW
- out_rd  out  REGNOBITS  destination register
- out_wr_reg  out  1  writes rd (forced 0 on bubble)
- out_inst_count  out  DBITS  passthrough

Behaviour:
- Reset:
  - All out_* are 0.
  - FSM enters IDLE; multiplier counter and accumulator are 0.
  - stall_o = 0, redirect_o = 0.
- Latency: one cycle for everything except MUL. Output latch updates on posedge clk.
- MEM never back-pressures the output latch.
- ALU ops:
  - ADD/SUB/AND/OR/XOR, register and immediate forms.
  - SLT/SLTU: signed / unsigned compare, result 0 or 1.
  - SLL/SRL/SRA: shift amount = operand[4:0].
  - LUI: result = imm.
  - AUIPC: result = pc + imm.
  - LW/SW: result = rs1 + imm. SW also sets out_store_data = rs2.
  - CSRR/CSRW: result = rs1, passed through.
  - All arithmetic wraps modulo 2^32.
- Control flow:
  - FE always predicts PC+4.
  - Taken branch (BEQ/BNE/BLT/BGE/BLTU/BGEU): redirect_o = 1, redirect_pc_o = pc + imm.
  - JAL: redirect to pc + imm.
  - JALR: redirect to (rs1 + imm) & ~1.
  - JAL and JALR: out_result = pc + 4.
  - A not-taken branch produces no redirect.
  - redirect_o is combinational from the in_* inputs, asserted only when in_valid = 1.
  - On redirect, DE inserts a bubble and FE loads redirect_pc_o at the same edge.
- MUL FSM, states IDLE and BUSY:
  - IDLE:
    - If in_valid and MUL: stall_o = 1; at the edge, capture multiplicand and multiplier, set counter = MUL_CYCLES-1, go to BUSY.
    - out_valid = 0 is written at that edge.
  - BUSY:
    - Retire MUL_RADIX_BITS per cycle via shift-add; result is the low 32 bits (sign-agnostic).
    - stall_o = 1 while counter != 0; each edge writes a bubble to the output latch.
  - BUSY with counter == 0:
    - stall_o = 0.
    - At the edge, write the product to the output latch with valid = 1 and return to IDLE.
    - The MUL still present on the inputs is not re-accepted.
  - Total: a MUL occupies the stage for MUL_CYCLES+1 cycles (33 at default).
- Invalid or unknown opcode with in_valid = 1: passes through with out_wr_reg = 0, out_result = 0, no redirect.
- Bubble input (in_valid = 0): out_valid = 0 and out_wr_reg = 0; no redirect.
- Reset during BUSY: the multiply is abandoned and the FSM returns to IDLE.

Optional Feature:
- Macro: AGEX_FAST_MUL_EN.
- Defined: MUL is a single-cycle combinational multiply. FSM and counter are removed, stall_o is tied to 0, and MUL latency is 1.
- Undefined: iterative FSM as above.

Decomposition:
- Shared package / define header holds:
  - The internal opcode enum (ADD_I … CSRW_I, INVALID_I) and IOPBITS.
  - DBITS and REGNOBITS.
  - AGEX latch field order and width, which the MEM stage unpacks.
- One natural sub-module: agex_iter_mul, a start/busy/done iterative multiplier parameterised by MUL_RADIX_BITS.

Test Plan:
- ADDI rs1=0x7FFFFFFF imm=1 rd=5 -> next cycle: out_result=0x80000000, out_rd=5, out_wr_reg=1, no redirect.
- BEQ pc=0x100 rs1=rs2=7 imm=0x20 -> same cycle: redirect_o=1, redirect_pc_o=0x120. BNE with the same operands -> redirect_o=0.
- JALR pc=0x200 rs1=0x1001 imm=2 -> redirect_pc_o=0x1002, out_result=0x204.
- MUL 0xFFFFFFFF×3, default params -> stall_o high 32 cycles, out_valid=0 throughout, then out_result=0xFFFFFFFD on the 33rd edge. The following ADD completes one cycle later.
- Assert reset at BUSY cycle 10 -> next cycle: FSM IDLE, stall_o=0, out_valid=0. A fresh MUL 6×7 yields 42.
- Bubble input with garbage operands -> out_valid=0, out_wr_reg=0, redirect_o=0.
